// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_t : transmitter FSM states (IDLE, START, DATA, PARITY, STOP)
//   START_BIT / STOP_BIT / IDLE_LEVEL : serial line levels
//   PAR_EVEN / PAR_ODD : encodings of the PAR_TYP control input
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;
  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register and bit-index counter for the UART transmitter.
// Ports:
//   CLK, RST   : bit-rate clock, synchronous active-low reset
//   load       : capture load_data and restart the bit index at 0
//   shift      : move the next data bit into bit_out (LSB first)
//   advance    : increment the bit index
//   load_data  : byte to be serialized
//   bit_out    : next data bit to put on the line
//   done       : bit index is at the last data bit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift,
  input  logic                  advance,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  bit_out,
  output logic                  done
);

  logic [DATA_WIDTH-1:0] shreg;
  logic [CNT_W-1:0]      idx;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= load_data;
      idx   <= '0;
    end else begin
      if (shift)   shreg <= shreg >> 1;
      if (advance) idx   <= idx + CNT_W'(1);
    end
  end

  // shreg[0] is always the bit the FSM registers onto the line at the next
  // edge, so TX_OUT stays a pure register with no mux on its output.
  assign bit_out = shreg[0];
  assign done    = (idx == CNT_W'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one CLK cycle per bit. Serializes a byte as
// start bit, DATA_WIDTH data bits (LSB first), optional parity, stop bit.
// Ports:
//   CLK        : bit-rate clock
//   RST        : synchronous active-low reset
//   P_DATA     : parallel data, captured when a frame is accepted
//   DATA_VALID : send request, honoured in IDLE and in the STOP cycle
//   PAR_EN     : insert a parity bit (captured with P_DATA)
//   PAR_TYP    : 0 = even parity, 1 = odd parity (captured with P_DATA)
//   TX_OUT     : registered serial line, idles high
//   BUSY       : registered, high from start bit through stop bit
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  tx_state_t state;
  logic      par_en_q;
  logic      par_bit_q;
  logic      accept;
  logic      shift;
  logic      advance;
  logic      ser_bit;
  logic      ser_done;

  // Parity of the incoming word, taken at acceptance so it never depends on
  // how far the shift register has advanced.
  function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d,
                                       input logic                  typ);
    return (^d) ^ (typ == PAR_ODD);
  endfunction

  always_comb begin
    accept  = DATA_VALID && ((state == IDLE) || (state == STOP));
    // START pre-shifts bit 0 into place; DATA shifts and counts until the
    // last data bit is on the line.
    advance = (state == DATA) && !ser_done;
    shift   = (state == START) || advance;
  end

  uart_tx_serializer #(
    .DATA_WIDTH(DATA_WIDTH),
    .CNT_W     (CNT_W)
  ) u_ser (
    .CLK      (CLK),
    .RST      (RST),
    .load     (accept),
    .shift    (shift),
    .advance  (advance),
    .load_data(P_DATA),
    .bit_out  (ser_bit),
    .done     (ser_done)
  );

  // The state names what is currently on the line; TX_OUT is loaded with
  // the level belonging to the next state.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      TX_OUT    <= IDLE_LEVEL;
      BUSY      <= 1'b0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (DATA_VALID) begin
            state     <= START;
            TX_OUT    <= START_BIT;
            BUSY      <= 1'b1;
            par_en_q  <= PAR_EN;
            par_bit_q <= calc_parity(P_DATA, PAR_TYP);
          end else begin
            state  <= IDLE;
            TX_OUT <= IDLE_LEVEL;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state  <= DATA;
          TX_OUT <= ser_bit;
          BUSY   <= 1'b1;
        end
        DATA: begin
          BUSY <= 1'b1;
          if (!ser_done) begin
            TX_OUT <= ser_bit;
          end else if (par_en_q) begin
            state  <= PARITY;
            TX_OUT <= par_bit_q;
          end else begin
            state  <= STOP;
            TX_OUT <= STOP_BIT;
          end
        end
        PARITY: begin
          state  <= STOP;
          TX_OUT <= STOP_BIT;
          BUSY   <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          TX_OUT <= IDLE_LEVEL;
          BUSY   <= 1'b0;
        end
      endcase
    end
  end

endmodule
